// File: rtl/stream_demux_if.sv
// Stream bundle for the 1-to-NUM_CH demultiplexer: one input stream plus
// NUM_CH flattened output streams.
interface stream_demux_if #(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 8,
  parameter int SEL_W  = 3
);
  logic                     in_valid;
  logic                     in_ready;
  logic [DATA_W-1:0]        in_data;
  logic [SEL_W-1:0]         in_sel;
  logic                     in_last;
  logic [NUM_CH-1:0]        out_valid;
  logic [NUM_CH-1:0]        out_ready;
  logic [NUM_CH*DATA_W-1:0] out_data;

  // Producer/consumer side (drives the input stream, sinks the outputs)
  modport master (
    output in_valid, in_data, in_sel, in_last, out_ready,
    input  in_ready, out_valid, out_data
  );

  // Demultiplexer side
  modport slave (
    input  in_valid, in_data, in_sel, in_last, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/stream_demux.sv
// Registered 1-to-NUM_CH stream demultiplexer with per-channel one-entry
// output registers, optional per-packet route locking and drop accounting
// for out-of-range selects.
module stream_demux #(
  parameter int DATA_W   = 8,
  parameter int NUM_CH   = 8,
  parameter int SEL_W    = 3,
  parameter int PKT_MODE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  stream_demux_if.slave    s,
  output logic             sel_err,
  output logic [7:0]       drop_cnt
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam logic [SEL_W:0] NUM_CH_L = (SEL_W+1)'(NUM_CH);

  state_t           state, state_nxt;
  logic [SEL_W-1:0] lock_sel, lock_sel_nxt;
  logic [SEL_W-1:0] eff_sel;
  logic             in_range;
  logic             slot_free;
  logic             accept;

  // Route selection, input handshake and packet FSM next-state
  always_comb begin
    eff_sel      = (state == LOCKED) ? lock_sel : s.in_sel;
    in_range     = ({1'b0, eff_sel} < NUM_CH_L);
    slot_free    = 1'b0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (eff_sel == SEL_W'(c)) slot_free = !s.out_valid[c] || s.out_ready[c];
    end
    // Out-of-range beats are always swallowed so a bad select cannot stall the producer
    s.in_ready   = en && (!in_range || slot_free);
    accept       = s.in_valid && s.in_ready;
    state_nxt    = state;
    lock_sel_nxt = lock_sel;
    if (PKT_MODE != 0 && accept) begin
      if (state == IDLE) begin
        lock_sel_nxt = s.in_sel;
        state_nxt    = s.in_last ? IDLE : LOCKED;
      end else if (s.in_last) begin
        state_nxt = IDLE;
      end
    end
  end

  // Packet FSM state and locked route
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      lock_sel <= '0;
    end else begin
      state    <= state_nxt;
      lock_sel <= lock_sel_nxt;
    end
  end

  // Per-channel output registers: load on accepted beat, else clear on drain
  always_ff @(posedge clk) begin
    if (rst) begin
      s.out_valid <= '0;
      s.out_data  <= '0;
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (accept && in_range && eff_sel == SEL_W'(c)) begin
          s.out_valid[c]                    <= 1'b1;
          s.out_data[c*DATA_W +: DATA_W]    <= s.in_data;
        end else if (s.out_ready[c]) begin
          s.out_valid[c] <= 1'b0;
        end
      end
    end
  end

  // Sticky error flag and saturating drop counter
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_err  <= 1'b0;
      drop_cnt <= '0;
    end else if (accept && !in_range) begin
      sel_err <= 1'b1;
      if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_stream_demux.sv
// Directed bench for stream_demux: three instances cover packet mode with
// 8 channels, per-beat mode with 8 channels, and packet mode with 6 channels.
module tb_stream_demux;

  logic       clk;
  logic       rst;
  logic       en_a, en_b, en_c;
  logic       sel_err_a, sel_err_b, sel_err_c;
  logic [7:0] drop_cnt_a, drop_cnt_b, drop_cnt_c;
  int         checks;
  int         failures;

  stream_demux_if #(.DATA_W(8), .NUM_CH(8), .SEL_W(3)) ia ();
  stream_demux_if #(.DATA_W(8), .NUM_CH(8), .SEL_W(3)) ib ();
  stream_demux_if #(.DATA_W(8), .NUM_CH(6), .SEL_W(3)) ic ();

  stream_demux #(.DATA_W(8), .NUM_CH(8), .SEL_W(3), .PKT_MODE(1)) dut_a (
    .clk(clk), .rst(rst), .en(en_a), .s(ia), .sel_err(sel_err_a), .drop_cnt(drop_cnt_a)
  );
  stream_demux #(.DATA_W(8), .NUM_CH(8), .SEL_W(3), .PKT_MODE(0)) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .s(ib), .sel_err(sel_err_b), .drop_cnt(drop_cnt_b)
  );
  stream_demux #(.DATA_W(8), .NUM_CH(6), .SEL_W(3), .PKT_MODE(1)) dut_c (
    .clk(clk), .rst(rst), .en(en_c), .s(ic), .sel_err(sel_err_c), .drop_cnt(drop_cnt_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ia.in_valid = 1'b1; ia.in_sel = 3'd0; ia.in_data = 8'hFF; ia.in_last = 1'b0;
    ib.in_valid = 1'b1; ib.in_sel = 3'd0; ib.in_data = 8'hFF; ib.in_last = 1'b0;
    ic.in_valid = 1'b1; ic.in_sel = 3'd0; ic.in_data = 8'hFF; ic.in_last = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    ia.in_valid = 1'b0; ib.in_valid = 1'b0; ic.in_valid = 1'b0;
    #1;
    checks++; if (ia.out_valid !== 8'h00) begin failures++; $display("FAIL rst_valid_a actual=%h expected=%h", ia.out_valid, 8'h00); end
    checks++; if (ia.out_data !== 64'h0) begin failures++; $display("FAIL rst_data_a actual=%h expected=%h", ia.out_data, 64'h0); end
    checks++; if (ib.out_valid !== 8'h00) begin failures++; $display("FAIL rst_valid_b actual=%h expected=%h", ib.out_valid, 8'h00); end
    checks++; if (ic.out_valid !== 6'h00) begin failures++; $display("FAIL rst_valid_c actual=%h expected=%h", ic.out_valid, 6'h00); end
    checks++; if (sel_err_a !== 1'b0) begin failures++; $display("FAIL rst_sel_err actual=%b expected=%b", sel_err_a, 1'b0); end
    checks++; if (drop_cnt_a !== 8'd0) begin failures++; $display("FAIL rst_drop_cnt actual=%0d expected=%0d", drop_cnt_a, 0); end
    en_a = 1'b0;
    #1;
    checks++; if (ia.in_ready !== 1'b0) begin failures++; $display("FAIL rst_ready_en0 actual=%b expected=%b", ia.in_ready, 1'b0); end
    en_a = 1'b1;
    #1;
    checks++; if (ia.in_ready !== 1'b1) begin failures++; $display("FAIL rst_ready_en1 actual=%b expected=%b", ia.in_ready, 1'b1); end
    tick();
    checks++; if (ia.out_valid !== 8'h00) begin failures++; $display("FAIL rst_idle_valid actual=%h expected=%h", ia.out_valid, 8'h00); end
  endtask

  task automatic test_per_beat();
    ib.out_ready = 8'hFF;
    ib.in_valid = 1'b1; ib.in_sel = 3'd2; ib.in_data = 8'hA5; ib.in_last = 1'b0;
    #1;
    checks++; if (ib.in_ready !== 1'b1) begin failures++; $display("FAIL beat_ready actual=%b expected=%b", ib.in_ready, 1'b1); end
    tick();
    ib.in_sel = 3'd7; ib.in_data = 8'h3C;
    checks++; if (ib.out_valid !== 8'h04) begin failures++; $display("FAIL beat1_valid actual=%h expected=%h", ib.out_valid, 8'h04); end
    checks++; if (ib.out_data[23:16] !== 8'hA5) begin failures++; $display("FAIL beat1_data actual=%h expected=%h", ib.out_data[23:16], 8'hA5); end
    tick();
    ib.in_valid = 1'b0;
    checks++; if (ib.out_valid !== 8'h80) begin failures++; $display("FAIL beat2_valid actual=%h expected=%h", ib.out_valid, 8'h80); end
    checks++; if (ib.out_data[63:56] !== 8'h3C) begin failures++; $display("FAIL beat2_data actual=%h expected=%h", ib.out_data[63:56], 8'h3C); end
    checks++; if (ib.out_data[23:16] !== 8'hA5) begin failures++; $display("FAIL beat_hold_data actual=%h expected=%h", ib.out_data[23:16], 8'hA5); end
    tick();
    checks++; if (ib.out_valid !== 8'h00) begin failures++; $display("FAIL beat_drain actual=%h expected=%h", ib.out_valid, 8'h00); end
  endtask

  task automatic test_back_pressure();
    ib.out_ready = 8'hEF;
    ib.in_valid = 1'b1; ib.in_sel = 3'd4; ib.in_data = 8'h11;
    #1;
    checks++; if (ib.in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready1 actual=%b expected=%b", ib.in_ready, 1'b1); end
    tick();
    ib.in_data = 8'h22;
    #1;
    checks++; if (ib.in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready2 actual=%b expected=%b", ib.in_ready, 1'b0); end
    tick();
    checks++; if (ib.out_valid !== 8'h10) begin failures++; $display("FAIL bp_hold_valid actual=%h expected=%h", ib.out_valid, 8'h10); end
    checks++; if (ib.out_data[39:32] !== 8'h11) begin failures++; $display("FAIL bp_hold_data actual=%h expected=%h", ib.out_data[39:32], 8'h11); end
    ib.out_ready = 8'hFF;
    #1;
    checks++; if (ib.in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready3 actual=%b expected=%b", ib.in_ready, 1'b1); end
    tick();
    ib.in_valid = 1'b0;
    checks++; if (ib.out_valid !== 8'h10) begin failures++; $display("FAIL bp_refill_valid actual=%h expected=%h", ib.out_valid, 8'h10); end
    checks++; if (ib.out_data[39:32] !== 8'h22) begin failures++; $display("FAIL bp_refill_data actual=%h expected=%h", ib.out_data[39:32], 8'h22); end
    tick();
    checks++; if (ib.out_valid !== 8'h00) begin failures++; $display("FAIL bp_no_dup actual=%h expected=%h", ib.out_valid, 8'h00); end
  endtask

  task automatic test_packet_lock();
    ia.out_ready = 8'hFF;
    ia.in_valid = 1'b1; ia.in_sel = 3'd1; ia.in_data = 8'hD1; ia.in_last = 1'b0;
    tick();
    ia.in_sel = 3'd5; ia.in_data = 8'hD2;
    checks++; if (ia.out_valid !== 8'h02 || ia.out_data[15:8] !== 8'hD1) begin failures++; $display("FAIL pkt_b1 valid=%h data=%h expected valid=%h data=%h", ia.out_valid, ia.out_data[15:8], 8'h02, 8'hD1); end
    tick();
    ia.in_sel = 3'd6; ia.in_data = 8'hD3; ia.in_last = 1'b1;
    checks++; if (ia.out_valid !== 8'h02 || ia.out_data[15:8] !== 8'hD2) begin failures++; $display("FAIL pkt_b2 valid=%h data=%h expected valid=%h data=%h", ia.out_valid, ia.out_data[15:8], 8'h02, 8'hD2); end
    tick();
    ia.in_sel = 3'd5; ia.in_data = 8'hD4; ia.in_last = 1'b1;
    checks++; if (ia.out_valid !== 8'h02 || ia.out_data[15:8] !== 8'hD3) begin failures++; $display("FAIL pkt_b3 valid=%h data=%h expected valid=%h data=%h", ia.out_valid, ia.out_data[15:8], 8'h02, 8'hD3); end
    tick();
    ia.in_valid = 1'b0;
    checks++; if (ia.out_valid !== 8'h20 || ia.out_data[47:40] !== 8'hD4) begin failures++; $display("FAIL pkt_next valid=%h data=%h expected valid=%h data=%h", ia.out_valid, ia.out_data[47:40], 8'h20, 8'hD4); end
    tick();
    checks++; if (ia.out_valid !== 8'h00) begin failures++; $display("FAIL pkt_drain actual=%h expected=%h", ia.out_valid, 8'h00); end
  endtask

  task automatic test_out_of_range();
    ic.out_ready = 6'h3F;
    ic.in_valid = 1'b1; ic.in_sel = 3'd7; ic.in_data = 8'h55; ic.in_last = 1'b1;
    #1;
    checks++; if (ic.in_ready !== 1'b1) begin failures++; $display("FAIL oor_ready actual=%b expected=%b", ic.in_ready, 1'b1); end
    tick();
    ic.in_valid = 1'b0;
    checks++; if (ic.out_valid !== 6'h00) begin failures++; $display("FAIL oor_valid actual=%h expected=%h", ic.out_valid, 6'h00); end
    checks++; if (sel_err_c !== 1'b1) begin failures++; $display("FAIL oor_sel_err actual=%b expected=%b", sel_err_c, 1'b1); end
    checks++; if (drop_cnt_c !== 8'd1) begin failures++; $display("FAIL oor_cnt1 actual=%0d expected=%0d", drop_cnt_c, 1); end
    // packet locked to channel 6 (== NUM_CH): both beats dropped
    ic.in_valid = 1'b1; ic.in_sel = 3'd6; ic.in_data = 8'h76; ic.in_last = 1'b0;
    tick();
    ic.in_sel = 3'd0; ic.in_data = 8'h77; ic.in_last = 1'b1;
    tick();
    ic.in_sel = 3'd0; ic.in_data = 8'h78; ic.in_last = 1'b1;
    checks++; if (ic.out_valid !== 6'h00) begin failures++; $display("FAIL oor_pkt_valid actual=%h expected=%h", ic.out_valid, 6'h00); end
    checks++; if (drop_cnt_c !== 8'd3) begin failures++; $display("FAIL oor_pkt_cnt actual=%0d expected=%0d", drop_cnt_c, 3); end
    tick();
    ic.in_valid = 1'b0;
    checks++; if (ic.out_valid !== 6'h01 || ic.out_data[7:0] !== 8'h78) begin failures++; $display("FAIL oor_recover valid=%h data=%h expected valid=%h data=%h", ic.out_valid, ic.out_data[7:0], 6'h01, 8'h78); end
    ic.in_valid = 1'b1; ic.in_sel = 3'd7; ic.in_last = 1'b1;
    for (int i = 0; i < 300; i++) tick();
    ic.in_valid = 1'b0;
    checks++; if (drop_cnt_c !== 8'd255) begin failures++; $display("FAIL oor_saturate actual=%0d expected=%0d", drop_cnt_c, 255); end
    checks++; if (ic.out_valid !== 6'h00) begin failures++; $display("FAIL oor_sat_valid actual=%h expected=%h", ic.out_valid, 6'h00); end
  endtask

  task automatic test_en_reset_mid_packet();
    ia.out_ready = 8'hFB;
    ia.in_valid = 1'b1; ia.in_sel = 3'd2; ia.in_data = 8'hE1; ia.in_last = 1'b0;
    tick();
    en_a = 1'b0;
    ia.in_sel = 3'd3; ia.in_data = 8'hE2;
    #1;
    checks++; if (ia.in_ready !== 1'b0) begin failures++; $display("FAIL en0_ready actual=%b expected=%b", ia.in_ready, 1'b0); end
    checks++; if (ia.out_valid !== 8'h04) begin failures++; $display("FAIL en0_held actual=%h expected=%h", ia.out_valid, 8'h04); end
    ia.out_ready = 8'hFF;
    tick();
    checks++; if (ia.out_valid !== 8'h00) begin failures++; $display("FAIL en0_drain actual=%h expected=%h", ia.out_valid, 8'h00); end
    en_a = 1'b1;
    ia.in_data = 8'hE3;
    tick();
    ia.in_valid = 1'b0;
    checks++; if (ia.out_valid !== 8'h04 || ia.out_data[23:16] !== 8'hE3) begin failures++; $display("FAIL en1_locked valid=%h data=%h expected valid=%h data=%h", ia.out_valid, ia.out_data[23:16], 8'h04, 8'hE3); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (ia.out_valid !== 8'h00) begin failures++; $display("FAIL midrst_valid actual=%h expected=%h", ia.out_valid, 8'h00); end
    ia.in_valid = 1'b1; ia.in_sel = 3'd3; ia.in_data = 8'hE4; ia.in_last = 1'b1;
    tick();
    ia.in_valid = 1'b0;
    checks++; if (ia.out_valid !== 8'h08 || ia.out_data[31:24] !== 8'hE4) begin failures++; $display("FAIL midrst_route valid=%h data=%h expected valid=%h data=%h", ia.out_valid, ia.out_data[31:24], 8'h08, 8'hE4); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    en_a = 1'b1; en_b = 1'b1; en_c = 1'b1;
    ia.in_valid = 1'b0; ia.in_sel = '0; ia.in_data = '0; ia.in_last = 1'b0; ia.out_ready = '1;
    ib.in_valid = 1'b0; ib.in_sel = '0; ib.in_data = '0; ib.in_last = 1'b0; ib.out_ready = '1;
    ic.in_valid = 1'b0; ic.in_sel = '0; ic.in_data = '0; ic.in_last = 1'b0; ic.out_ready = '1;
    test_reset();
    test_per_beat();
    test_back_pressure();
    test_packet_lock();
    test_out_of_range();
    test_en_reset_mid_packet();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
